// File: rtl/fx2_out_cmd_reader.sv
// fx2_out_cmd_reader: FX2 EP8 slave-FIFO reader that parses 2-byte register-write commands.
module fx2_out_cmd_reader #(
  parameter int          GAP_CYCLES      = 2,
  parameter logic [63:0] REG_RESET_VALUE = 64'h0000_0000_0000_0001
) (
  input  logic        FX2_IFCLK,
  input  logic        MAX2_nRESET,
  input  logic        MAX2_FIFO_DIR,
  input  logic        READ_ENABLE,
  input  logic        FX2_FLAGC,
  input  logic [7:0]  FX2_FD,
  output logic        FX2_SLOE,
  output logic        FX2_SLRD,
  output logic [1:0]  FX2_FIFOADDR,
  output logic        BUS_ACTIVE,
  output logic [63:0] REG_Q,
  output logic        REG_WR_STB,
  output logic [2:0]  REG_WR_ADDR,
  output logic [7:0]  REG_WR_DATA,
  input  logic [2:0]  REG_RD_ADDR,
  output logic [7:0]  REG_RD_DATA,
  output logic [7:0]  ERR_COUNT
);
  typedef enum logic [1:0] {IDLE, SETUP, SAMPLE, GAP} state_t;
  state_t state, state_nx;
  logic       go, sloe_nx, slrd_nx, byte_vld, in_data;
  logic [2:0] gap_cnt, addr_q;
  logic [7:0] byte_q;
  assign go           = MAX2_FIFO_DIR & READ_ENABLE;
  assign BUS_ACTIVE   = state != IDLE;
  assign FX2_FIFOADDR = 2'b11;
  assign REG_RD_DATA  = REG_Q[8*REG_RD_ADDR +: 8];
  // Strobes are registered from the next state so the pins match the state exactly.
  always_ff @(posedge FX2_IFCLK or negedge MAX2_nRESET)
    if (!MAX2_nRESET) begin
      state    <= IDLE;
      gap_cnt  <= '0;
      FX2_SLOE <= 1'b1;
      FX2_SLRD <= 1'b1;
    end else begin
      state    <= state_nx;
      FX2_SLOE <= sloe_nx;
      FX2_SLRD <= slrd_nx;
      gap_cnt  <= state == SAMPLE ? 3'(GAP_CYCLES - 1) : gap_cnt != 0 ? gap_cnt - 3'd1 : 3'd0;
    end
  always_comb
    state_nx = state == IDLE   ? (go && FX2_FLAGC ? SETUP : IDLE) :
               state == SETUP  ? (go ? SAMPLE : IDLE) :
               state == SAMPLE ? GAP :
               gap_cnt != 0    ? GAP :
               go && FX2_FLAGC ? SAMPLE : IDLE;
  always_comb begin
    sloe_nx = state_nx == IDLE;
    slrd_nx = state_nx != SAMPLE;
  end
  always_ff @(posedge FX2_IFCLK or negedge MAX2_nRESET)
    if (!MAX2_nRESET) begin
      byte_vld <= 1'b0;
      byte_q   <= '0;
    end else begin
      byte_vld <= state == SAMPLE;
      if (state == SAMPLE) byte_q <= FX2_FD;
    end
  // A byte already consumed from the FIFO is parsed even if the direction flips that cycle.
  always_ff @(posedge FX2_IFCLK or negedge MAX2_nRESET)
    if (!MAX2_nRESET) begin
      in_data     <= 1'b0;
      addr_q      <= '0;
      REG_Q       <= REG_RESET_VALUE;
      REG_WR_STB  <= 1'b0;
      REG_WR_ADDR <= '0;
      REG_WR_DATA <= '0;
      ERR_COUNT   <= '0;
    end else begin
      REG_WR_STB <= byte_vld & in_data;
      if (byte_vld) begin
        if (in_data) begin
          REG_Q[8*addr_q +: 8] <= byte_q;
          REG_WR_ADDR          <= addr_q;
          REG_WR_DATA          <= byte_q;
          in_data              <= 1'b0;
        end else if (byte_q[7:3] == 5'b10000) begin
          addr_q  <= byte_q[2:0];
          in_data <= 1'b1;
        end else if (ERR_COUNT != 8'hFF) ERR_COUNT <= ERR_COUNT + 8'd1;
      end else if (!MAX2_FIFO_DIR) in_data <= 1'b0;
    end
endmodule

// File: doc/fx2_out_cmd_reader.md
Name: fx2_out_cmd_reader

Overview:
- Reader for the FX2 slave-FIFO OUT endpoint (EP8, FIFOADDR 2'b11), used when MAX2_FIFO_DIR selects PC-to-FX2.
- Pulls bytes with synchronous SLOE/SLRD reads and parses 2-byte register-write commands.
- Holds the MAX2 control register file: 8 x 8-bit registers, e.g. reg 0 bit 0 = external sound enable.
- Sits beside the capture/transfer path; the top level muxes FX2 strobes and FIFOADDR onto the pins using BUS_ACTIVE.

Parameters:
- GAP_CYCLES, 2, idle cycles after each SLRD pulse before FX2_FLAGC is trusted again (FX2 flag latency); legal range 1..7.
- REG_RESET_VALUE, 64'h0000_0000_0000_0001, reset contents; register n = bits [8n+7:8n].

Ports:
- FX2_IFCLK  in  1  48 MHz interface clock; all logic on the rising edge.
- MAX2_nRESET  in  1  asynchronous, active-low reset.
- MAX2_FIFO_DIR  in  1  1 = PC-to-FX2 (reader may run), 0 = FX2-to-PC.
- READ_ENABLE  in  1  1 = reader permitted to start new reads.
- FX2_FLAGC  in  1  EP8 empty flag, active-low (0 = empty).
- FX2_FD  in  8  FIFO data bus (tri-state handled at top level).
- FX2_SLOE  out  1  active-low output enable, registered.
- FX2_SLRD  out  1  active-low read strobe, registered.
- FX2_FIFOADDR  out  2  constant 2'b11.
- BUS_ACTIVE  out  1  1 while the FSM is not IDLE; the top level gives the pins to this block.
- REG_Q  out  64  flattened register file.
- REG_WR_STB  out  1  one-cycle pulse per completed register write.
- REG_WR_ADDR  out  3  address of the last write.
- REG_WR_DATA  out  8  data of the last write.
- REG_RD_ADDR  in  3  readback address.
- REG_RD_DATA  out  8  combinational: REG_Q[8*REG_RD_ADDR +: 8].
- ERR_COUNT  out  8  framing-error count, saturates at 8'hFF.

Behaviour:
- Reset (async, MAX2_nRESET=0), effective immediately:
  - FSM = IDLE; FX2_SLOE=1, FX2_SLRD=1, BUS_ACTIVE=0.
  - REG_Q = REG_RESET_VALUE.
  - REG_WR_STB=0, REG_WR_ADDR=0, REG_WR_DATA=0, ERR_COUNT=0.
  - Parser = HEADER, gap counter = 0.
  - Reset mid-read abandons the byte; no partial register write.
- go = MAX2_FIFO_DIR==1 && READ_ENABLE==1.
- FSM states:
  - IDLE: SLOE=1, SLRD=1. If go && FX2_FLAGC==1 -> SETUP.
  - SETUP: SLOE=0, SLRD=1. Single cycle for FD turn-on. Next: go ? SAMPLE : IDLE.
  - SAMPLE: SLOE=0, SLRD=0 for exactly one cycle. FX2_FD is captured at the rising edge that ends this cycle, and the FX2 pops the byte on the same edge. The byte is always consumed, even if go drops during SAMPLE. Next: GAP.
  - GAP: SLOE=0, SLRD=1 for GAP_CYCLES cycles (counter reload on entry). On the last cycle:
    - go && FX2_FLAGC==1 -> SAMPLE.
    - otherwise -> IDLE (SLOE returns to 1 on entry to IDLE).
- Throughput: one byte per 1+GAP_CYCLES clocks. First SLRD low occurs 2 clocks after FLAGC is seen in IDLE.
- SLRD is never low while SLOE is high. SLRD is never low on two consecutive cycles.
- Parser (advances one step per captured byte):
  - HEADER, byte[7]==1 && byte[6:3]==0: latch addr=byte[2:0] -> DATA.
  - HEADER, any other byte: ERR_COUNT+1 (saturating), byte discarded, stay in HEADER (resync).
  - DATA: register[addr] <= byte. REG_WR_ADDR/REG_WR_DATA updated. REG_WR_STB=1 on the cycle after capture. Parser -> HEADER.
- Write latency: REG_Q changes on the same edge REG_WR_STB rises, 1 clock after the data-byte capture edge.
- Pending header: if MAX2_FIFO_DIR goes 0 while the parser is in DATA, the header is discarded (parser -> HEADER on the next clock) and no error is counted. READ_ENABLE=0 alone keeps the pending header.
- Simultaneous events: FLAGC falling during GAP is only sampled on the last GAP cycle. FLAGC is ignored in SETUP and SAMPLE.
- Writes to the same address: last write wins. There are no read side effects.

Test Plan:
- Reset: assert MAX2_nRESET=0 mid-SAMPLE -> SLOE=SLRD=1 immediately, REG_Q=64'h...0001, ERR_COUNT=0, no REG_WR_STB.
- Single command: FIFO holds {8'h83, 8'h5A}, DIR=1, EN=1, GAP_CYCLES=2 -> SLRD low exactly 2 cycles, 3 clocks apart. REG_Q[31:24]=8'h5A. One REG_WR_STB with ADDR=3, DATA=8'h5A. BUS_ACTIVE falls after FLAGC=0.
- Framing resync: bytes {8'h12, 8'hC0, 8'h80, 8'h00} -> ERR_COUNT=2 (8'h12, 8'hC0), reg 0 = 8'h00, one strobe.
- Saturation: 300 bytes of 8'h00 -> ERR_COUNT=8'hFF, no writes.
- Direction drop: send header 8'h81, drop DIR during GAP -> FSM returns to IDLE. Header is discarded. A later {8'h05} on DIR=1 counts 1 error and produces no write.
- Empty flag: FLAGC=0 throughout with DIR=1 -> FSM stays IDLE, SLOE=1, SLRD=1, BUS_ACTIVE=0 for 100 cycles.
